mm_seq_ctrl: RTL and testbench

Parametrised command sequencer for the matrix-multiply accelerator. It replaces the level-start controller with a valid/ready command port, single-cycle start pulses, a multi-tile FULL mode (load A, load B, compute, store C per tile with address auto-advance), a completion watchdog and abort. It sits between the CPU register block and the DMA/PE array.

---
 rtl/mm_seq_ctrl_if.sv | 55 +++++
 rtl/mm_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_seq_ctrl_if.sv
// Command, DMA and PE signal bundle for the matrix-multiply sequencer.
// master = CPU/DMA/PE side, slave = the sequencer itself.
interface mm_seq_ctrl_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LENGTH_W = 8,
    parameter int unsigned TILE_W   = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [ADDR_W-1:0]   cmd_addr_a;
    logic [ADDR_W-1:0]   cmd_addr_b;
    logic [ADDR_W-1:0]   cmd_addr_c;
    logic [LENGTH_W-1:0] cmd_len_a;
    logic [LENGTH_W-1:0] cmd_len_b;
    logic [LENGTH_W-1:0] cmd_len_c;
    logic [TILE_W-1:0]   cmd_tiles;
    logic                cmd_abort;
    logic                busy;
    logic                done_pulse;
    logic [1:0]          err_code;
    logic [TILE_W-1:0]   tile_idx;
    logic                dma_start_load_a;
    logic                dma_start_load_b;
    logic                dma_start_store_c;
    logic [ADDR_W-1:0]   dma_addr_a;
    logic [ADDR_W-1:0]   dma_addr_b;
    logic [ADDR_W-1:0]   dma_addr_c;
    logic [LENGTH_W-1:0] dma_len_a;
    logic [LENGTH_W-1:0] dma_len_b;
    logic [LENGTH_W-1:0] dma_len_c;
    logic                dma_done_load_a;
    logic                dma_done_load_b;
    logic                dma_done_store_c;
    logic                pe_start;
    logic                pe_done;

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_c,
               cmd_len_a, cmd_len_b, cmd_len_c, cmd_tiles, cmd_abort,
               dma_done_load_a, dma_done_load_b, dma_done_store_c, pe_done,
        input  cmd_ready, busy, done_pulse, err_code, tile_idx,
               dma_start_load_a, dma_start_load_b, dma_start_store_c,
               dma_addr_a, dma_addr_b, dma_addr_c, dma_len_a, dma_len_b, dma_len_c, pe_start
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_c,
               cmd_len_a, cmd_len_b, cmd_len_c, cmd_tiles, cmd_abort,
               dma_done_load_a, dma_done_load_b, dma_done_store_c, pe_done,
        output cmd_ready, busy, done_pulse, err_code, tile_idx,
               dma_start_load_a, dma_start_load_b, dma_start_store_c,
               dma_addr_a, dma_addr_b, dma_addr_c, dma_len_a, dma_len_b, dma_len_c, pe_start
    );
endinterface

// File: rtl/mm_seq_ctrl.sv
// Command sequencer for the matrix-multiply accelerator: issues DMA/PE start pulses per op,
// walks FULL commands over tiles with address auto-advance, with watchdog and abort.
module mm_seq_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LENGTH_W    = 8,
    parameter int unsigned TILE_W      = 8,
    parameter int unsigned ADDR_SHIFT  = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic          clk,
    input logic          rst_n,
    mm_seq_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StLaIss, StLaWait, StLbIss, StLbWait, StPeIss, StPeWait,
        StScIss, StScWait, StNext, StDone, StErr
    } state_e;

    localparam logic [1:0] OpLoadA   = 2'd0;
    localparam logic [1:0] OpLoadB   = 2'd1;
    localparam logic [1:0] OpCompute = 2'd2;
    localparam logic [1:0] OpFull    = 2'd3;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrTimeout = 2'd1;
    localparam logic [1:0] ErrAbort   = 2'd2;

    localparam int unsigned      WdW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WdW-1:0]   WdLast = WdW'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [TILE_W-1:0]   tiles_q, tiles_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [1:0]          err_q, err_d;
    logic [WdW-1:0]      wdog_q, wdog_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [LENGTH_W-1:0] len_a_q, len_a_d, len_b_q, len_b_d, len_c_q, len_c_d;
    logic                in_wait;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpLoadA;
            tiles_q  <= '0;
            tile_q   <= '0;
            err_q    <= ErrNone;
            wdog_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            len_a_q  <= '0;
            len_b_q  <= '0;
            len_c_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tiles_q  <= tiles_d;
            tile_q   <= tile_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            len_a_q  <= len_a_d;
            len_b_q  <= len_b_d;
            len_c_q  <= len_c_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tiles_d  = tiles_q;
        tile_d   = tile_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
        len_a_d  = len_a_q;
        len_b_d  = len_b_q;
        len_c_d  = len_c_q;
        in_wait  = 1'b0;

        // Abort beats any same-cycle done and any NEXT address advance.
        if (state_q != StIdle && bus.cmd_abort) begin
            state_d = StIdle;
            err_d   = ErrAbort;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        op_d     = bus.cmd_op;
                        tiles_d  = (bus.cmd_tiles == '0) ? TILE_W'(1) : bus.cmd_tiles;
                        tile_d   = '0;
                        err_d    = ErrNone;
                        addr_a_d = bus.cmd_addr_a;
                        addr_b_d = bus.cmd_addr_b;
                        addr_c_d = bus.cmd_addr_c;
                        len_a_d  = bus.cmd_len_a;
                        len_b_d  = bus.cmd_len_b;
                        len_c_d  = bus.cmd_len_c;
                        case (bus.cmd_op)
                            OpLoadB:   state_d = StLbIss;
                            OpCompute: state_d = StPeIss;
                            default:   state_d = StLaIss;
                        endcase
                    end
                end
                StLaIss: begin
                    wdog_d  = '0;
                    state_d = StLaWait;
                end
                StLaWait: begin
                    in_wait = 1'b1;
                    if (bus.dma_done_load_a) state_d = (op_q == OpFull) ? StLbIss : StDone;
                end
                StLbIss: begin
                    wdog_d  = '0;
                    state_d = StLbWait;
                end
                StLbWait: begin
                    in_wait = 1'b1;
                    if (bus.dma_done_load_b) state_d = (op_q == OpFull) ? StPeIss : StDone;
                end
                StPeIss: begin
                    wdog_d  = '0;
                    state_d = StPeWait;
                end
                StPeWait: begin
                    in_wait = 1'b1;
                    if (bus.pe_done) state_d = StScIss;
                end
                StScIss: begin
                    wdog_d  = '0;
                    state_d = StScWait;
                end
                StScWait: begin
                    in_wait = 1'b1;
                    if (bus.dma_done_store_c) state_d = (op_q == OpFull) ? StNext : StDone;
                end
                StNext: begin
                    if (tile_q == tiles_q - TILE_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        tile_d   = tile_q + TILE_W'(1);
                        addr_a_d = addr_a_q + (ADDR_W'(len_a_q) << ADDR_SHIFT);
                        addr_b_d = addr_b_q + (ADDR_W'(len_b_q) << ADDR_SHIFT);
                        addr_c_d = addr_c_q + (ADDR_W'(len_c_q) << ADDR_SHIFT);
                        state_d  = StLaIss;
                    end
                end
                StDone, StErr: state_d = StIdle;
                default:       state_d = StIdle;
            endcase

            // Watchdog only counts WAIT cycles that did not see their done.
            if (in_wait && state_d == state_q && TIMEOUT_CYC != 0) begin
                if (wdog_q == WdLast) begin
                    state_d = StErr;
                    err_d   = ErrTimeout;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
        end
    end

    assign bus.cmd_ready         = (state_q == StIdle);
    assign bus.busy              = (state_q != StIdle);
    assign bus.done_pulse        = (state_q == StDone) || (state_q == StErr);
    assign bus.dma_start_load_a  = (state_q == StLaIss);
    assign bus.dma_start_load_b  = (state_q == StLbIss);
    assign bus.dma_start_store_c = (state_q == StScIss);
    assign bus.pe_start          = (state_q == StPeIss);
    assign bus.err_code          = err_q;
    assign bus.tile_idx          = tile_q;
    assign bus.dma_addr_a        = addr_a_q;
    assign bus.dma_addr_b        = addr_b_q;
    assign bus.dma_addr_c        = addr_c_q;
    assign bus.dma_len_a         = len_a_q;
    assign bus.dma_len_b         = len_b_q;
    assign bus.dma_len_c         = len_c_q;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: delayed-done responder, pulse monitor, hand-computed checks.
module tb_mm_seq_ctrl;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LENGTH_W    = 8;
    localparam int unsigned TILE_W      = 8;
    localparam int unsigned ADDR_SHIFT  = 2;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_seq_ctrl_if #(.ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W), .TILE_W(TILE_W)) bus ();

    mm_seq_ctrl #(
        .ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W), .TILE_W(TILE_W),
        .ADDR_SHIFT(ADDR_SHIFT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Responder: done for channel i arrives dly[i] cycles after its start pulse (a,b,c,pe).
    int   dly[4];
    int   cnt[4];
    logic [3:0] dn = '0;
    logic [3:0] st;
    bit   pe_en = 1'b1;
    bit   abort_arm = 1'b0;
    logic abort_resp = 1'b0;
    logic abort_main = 1'b0;
    int   abort_cyc = 0;

    assign bus.dma_done_load_a  = dn[0];
    assign bus.dma_done_load_b  = dn[1];
    assign bus.dma_done_store_c = dn[2];
    assign bus.pe_done          = dn[3];
    assign bus.cmd_abort        = abort_resp | abort_main;

    // Monitor state, indexed by absolute event counts.
    int n_la = 0, n_lb = 0, n_pe = 0, n_sc = 0, n_done = 0, n_seq = 0;
    int la_cyc = 0, done_cyc = 0, ready_cyc = 0;
    logic [1:0]        err_at_done = '0;
    logic [31:0]       la_addr[64];
    logic [31:0]       lb_addr[64];
    logic [31:0]       sc_addr[64];
    logic [TILE_W-1:0] la_tile[64];
    int                seq[64];
    bit                prev_ready = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        st = {bus.pe_start, bus.dma_start_store_c, bus.dma_start_load_b, bus.dma_start_load_a};
        abort_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dn[i] = 1'b0;
            if (!rst_n) begin
                cnt[i] = 0;
            end else begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0 && (i != 3 || pe_en)) dn[i] = 1'b1;
                end
                if (st[i] === 1'b1) cnt[i] = dly[i];
            end
        end
        if (dn[3] && abort_arm && bus.tile_idx == TILE_W'(1)) begin
            abort_resp = 1'b1;
            abort_cyc  = cyc;
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.dma_start_load_a === 1'b1) begin
            la_addr[n_la % 64] = bus.dma_addr_a;
            la_tile[n_la % 64] = bus.tile_idx;
            la_cyc = cyc;
            n_la++;
            seq[n_seq % 64] = 0;
            n_seq++;
        end
        if (bus.dma_start_load_b === 1'b1) begin
            lb_addr[n_lb % 64] = bus.dma_addr_b;
            n_lb++;
            seq[n_seq % 64] = 1;
            n_seq++;
        end
        if (bus.dma_start_store_c === 1'b1) begin
            sc_addr[n_sc % 64] = bus.dma_addr_c;
            n_sc++;
            seq[n_seq % 64] = 2;
            n_seq++;
        end
        if (bus.pe_start === 1'b1) begin
            n_pe++;
            seq[n_seq % 64] = 3;
            n_seq++;
        end
        if (bus.done_pulse === 1'b1) begin
            n_done++;
            done_cyc    = cyc;
            err_at_done = bus.err_code;
        end
        if (bus.cmd_ready === 1'b1 && !prev_ready) ready_cyc = cyc;
        prev_ready = (bus.cmd_ready === 1'b1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] aa, input logic [31:0] ab,
                            input logic [31:0] ac, input logic [7:0] la, input logic [7:0] lb,
                            input logic [7:0] lc, input logic [7:0] tiles, input logic abort_with,
                            output int acc);
        @(posedge clk);
        #1;
        bus.cmd_op     = op;
        bus.cmd_addr_a = aa;
        bus.cmd_addr_b = ab;
        bus.cmd_addr_c = ac;
        bus.cmd_len_a  = la;
        bus.cmd_len_b  = lb;
        bus.cmd_len_c  = lc;
        bus.cmd_tiles  = tiles;
        bus.cmd_valid  = 1'b1;
        abort_main     = abort_with;
        acc            = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        abort_main    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== 1'b0 && n < budget);
        check_val({tag, " idle"}, 64'(bus.busy), 64'd0);
    endtask

    int acc;
    int b_la, b_lb, b_pe, b_sc, b_done, b_seq;
    int exp_seq[4];

    task automatic snap();
        b_la = n_la; b_lb = n_lb; b_pe = n_pe; b_sc = n_sc; b_done = n_done; b_seq = n_seq;
    endtask

    initial begin
        exp_seq = '{0, 1, 3, 2};
        dly = '{1, 1, 1, 1};
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_addr_a = '0; bus.cmd_addr_b = '0; bus.cmd_addr_c = '0;
        bus.cmd_len_a = '0;  bus.cmd_len_b = '0;  bus.cmd_len_c = '0;
        bus.cmd_tiles = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst ready", 64'(bus.cmd_ready), 64'd1);
        check_val("rst busy", 64'(bus.busy), 64'd0);
        check_val("rst err", 64'(bus.err_code), 64'd0);
        check_val("rst tile", 64'(bus.tile_idx), 64'd0);
        check_val("rst addr_a", 64'(bus.dma_addr_a), 64'd0);
        check_val("rst len_c", 64'(bus.dma_len_c), 64'd0);
        check_val("rst pulses", 64'({bus.done_pulse, bus.dma_start_load_a, bus.dma_start_load_b,
                                    bus.dma_start_store_c, bus.pe_start}), 64'd0);

        // LOAD_A, DMA done 5 cycles after the pulse
        dly = '{5, 1, 1, 1};
        snap();
        send_cmd(2'd0, 32'h1000, 32'h0, 32'h0, 8'd16, 8'd0, 8'd0, 8'd0, 1'b0, acc);
        @(negedge clk);
        check_val("la busy", 64'(bus.busy), 64'd1);
        check_val("la ready", 64'(bus.cmd_ready), 64'd0);
        wait_idle("la", 200);
        check_val("la n_pulse", 64'(n_la - b_la), 64'd1);
        check_val("la pulse cyc", 64'(la_cyc - acc), 64'd1);
        check_val("la done cyc", 64'(done_cyc - acc), 64'd7);
        check_val("la n_done", 64'(n_done - b_done), 64'd1);
        check_val("la err", 64'(err_at_done), 64'd0);
        check_val("la addr", 64'(bus.dma_addr_a), 64'h1000);
        check_val("la len", 64'(bus.dma_len_a), 64'd16);
        check_val("la n_lb", 64'(n_lb - b_lb), 64'd0);

        // FULL, 3 tiles; per tile 4 ISS + (1+2+1+3) WAIT + NEXT = 12 cycles
        dly = '{1, 2, 1, 3};
        snap();
        send_cmd(2'd3, 32'h100, 32'h2000, 32'h3000, 8'd8, 8'd4, 8'd2, 8'd3, 1'b0, acc);
        wait_idle("full", 400);
        for (int t = 0; t < 3; t++) begin
            check_val($sformatf("full la_addr%0d", t), 64'(la_addr[(b_la + t) % 64]),
                      64'(32'h100 + 32'(t) * 32'h20));
            check_val($sformatf("full tile%0d", t), 64'(la_tile[(b_la + t) % 64]), 64'(t));
            check_val($sformatf("full lb_addr%0d", t), 64'(lb_addr[(b_lb + t) % 64]),
                      64'(32'h2000 + 32'(t) * 32'h10));
            check_val($sformatf("full sc_addr%0d", t), 64'(sc_addr[(b_sc + t) % 64]),
                      64'(32'h3000 + 32'(t) * 32'h8));
        end
        check_val("full n_seq", 64'(n_seq - b_seq), 64'd12);
        for (int k = 0; k < 12; k++) begin
            check_val($sformatf("full seq%0d", k), 64'(seq[(b_seq + k) % 64]), 64'(exp_seq[k % 4]));
        end
        check_val("full n_done", 64'(n_done - b_done), 64'd1);
        check_val("full done cyc", 64'(done_cyc - acc), 64'd37);
        check_val("full last tile", 64'(bus.tile_idx), 64'd2);

        // COMPUTE with pe_done withheld: 16 WAIT cycles then ERR
        pe_en = 1'b0;
        snap();
        send_cmd(2'd2, 32'h0, 32'h0, 32'h7000, 8'd1, 8'd1, 8'd1, 8'd0, 1'b0, acc);
        wait_idle("to", 200);
        pe_en = 1'b1;
        check_val("to n_pe", 64'(n_pe - b_pe), 64'd1);
        check_val("to n_sc", 64'(n_sc - b_sc), 64'd0);
        check_val("to n_done", 64'(n_done - b_done), 64'd1);
        check_val("to err at done", 64'(err_at_done), 64'd1);
        check_val("to done cyc", 64'(done_cyc - acc), 64'd18);
        check_val("to err sticky", 64'(bus.err_code), 64'd1);

        // COMPUTE normal: PE then store C; error cleared on accept
        dly = '{1, 1, 3, 2};
        snap();
        send_cmd(2'd2, 32'h0, 32'h0, 32'h7000, 8'd1, 8'd1, 8'd1, 8'd0, 1'b0, acc);
        wait_idle("cmp", 200);
        check_val("cmp n_sc", 64'(n_sc - b_sc), 64'd1);
        check_val("cmp sc addr", 64'(sc_addr[b_sc % 64]), 64'h7000);
        check_val("cmp err", 64'(err_at_done), 64'd0);
        check_val("cmp done cyc", 64'(done_cyc - acc), 64'd8);

        // FULL aborted in tile 1 PE_WAIT together with pe_done
        dly = '{1, 1, 1, 1};
        abort_arm = 1'b1;
        snap();
        send_cmd(2'd3, 32'h100, 32'h200, 32'h300, 8'd1, 8'd1, 8'd1, 8'd3, 1'b0, acc);
        wait_idle("abt", 400);
        abort_arm = 1'b0;
        check_val("abt n_la", 64'(n_la - b_la), 64'd2);
        check_val("abt n_pe", 64'(n_pe - b_pe), 64'd2);
        check_val("abt n_sc", 64'(n_sc - b_sc), 64'd1);
        check_val("abt n_done", 64'(n_done - b_done), 64'd0);
        check_val("abt err", 64'(bus.err_code), 64'd2);
        check_val("abt ready cyc", 64'(ready_cyc - abort_cyc), 64'd1);

        // Reset in LB_WAIT, then a fresh LOAD_B
        dly = '{1, 50, 1, 1};
        snap();
        send_cmd(2'd1, 32'h0, 32'h5000, 32'h0, 8'd0, 8'd7, 8'd0, 8'd0, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1;
        check_val("rst2 busy before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst2 ready", 64'(bus.cmd_ready), 64'd1);
        check_val("rst2 busy", 64'(bus.busy), 64'd0);
        check_val("rst2 err", 64'(bus.err_code), 64'd0);
        check_val("rst2 addr_b", 64'(bus.dma_addr_b), 64'd0);
        check_val("rst2 len_b", 64'(bus.dma_len_b), 64'd0);
        check_val("rst2 n_done", 64'(n_done - b_done), 64'd0);
        dly = '{1, 2, 1, 1};
        snap();
        send_cmd(2'd1, 32'h0, 32'h4444, 32'h0, 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, acc);
        wait_idle("lb", 200);
        check_val("lb n_pulse", 64'(n_lb - b_lb), 64'd1);
        check_val("lb addr", 64'(lb_addr[b_lb % 64]), 64'h4444);
        check_val("lb done cyc", 64'(done_cyc - acc), 64'd4);
        check_val("lb err", 64'(err_at_done), 64'd0);

        // FULL with tiles=0 runs exactly one tile
        dly = '{1, 1, 1, 1};
        snap();
        send_cmd(2'd3, 32'hFFFF_FFF0, 32'h0, 32'h0, 8'd8, 8'd1, 8'd1, 8'd0, 1'b0, acc);
        wait_idle("t0", 200);
        check_val("t0 n_la", 64'(n_la - b_la), 64'd1);
        check_val("t0 la addr", 64'(la_addr[b_la % 64]), 64'hFFFF_FFF0);
        check_val("t0 n_done", 64'(n_done - b_done), 64'd1);
        check_val("t0 done cyc", 64'(done_cyc - acc), 64'd10);

        // Two tiles with address wrap; abort offered in IDLE alongside the command is ignored
        snap();
        send_cmd(2'd3, 32'hFFFF_FFF0, 32'h0, 32'h0, 8'd8, 8'd1, 8'd1, 8'd2, 1'b1, acc);
        wait_idle("wrap", 200);
        check_val("wrap n_la", 64'(n_la - b_la), 64'd2);
        check_val("wrap addr0", 64'(la_addr[b_la % 64]), 64'hFFFF_FFF0);
        check_val("wrap addr1", 64'(la_addr[(b_la + 1) % 64]), 64'h0000_0010);
        check_val("wrap n_done", 64'(n_done - b_done), 64'd1);
        check_val("wrap err", 64'(err_at_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
